fib_bcd: RTL

Sequential binary-to-BCD converter that sits directly downstream of `fib`. It takes the unsigned binary `result` word and converts it to packed decimal digits using shift-and-add-3 (double dabble), one bit per clock. It also reports how many significant digits the value has, for the display/UART stage that follows. It uses the same 4-phase `req`/`ack` handshake as `fib`, so `fib.ack` can drive `req` directly.

---
 rtl/fib_bcd.sv | 115 +++++++++++
 1 files changed

// File: rtl/fib_bcd.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with
// significant-digit count, using a 4-phase req/ack handshake.
module fib_bcd #(
  parameter int N_IN  = 64,
  parameter int N_DIG = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [N_IN-1:0]      bin,
  output logic                 ack,
  output logic [4*N_DIG-1:0]   bcd,
  output logic [7:0]           ndig
);

  localparam int CNT_W = $clog2(N_IN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_IN-1:0]      shift_q, shift_d;
  logic [4*N_DIG-1:0]   work_q, work_d;
  logic [4*N_DIG-1:0]   adj;
  logic [4*N_DIG-1:0]   bcd_q, bcd_d;
  logic [7:0]           ndig_q, ndig_d;
  logic                 ack_q, ack_d;

  // Pre-shift correction: any digit >= 5 would overflow past 9 once doubled.
  function automatic logic [4*N_DIG-1:0] add3_all(input logic [4*N_DIG-1:0] w);
    logic [4*N_DIG-1:0] r;
    r = w;
    for (int i = 0; i < N_DIG; i++) begin
      if (w[4*i +: 4] >= 4'd5) r[4*i +: 4] = w[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [7:0] count_digits(input logic [4*N_DIG-1:0] w);
    logic [7:0] n;
    n = 8'd1;
    for (int i = 0; i < N_DIG; i++) begin
      if (w[4*i +: 4] != 4'd0) n = 8'(i + 1);
    end
    return n;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    work_d  = work_q;
    bcd_d   = bcd_q;
    ndig_d  = ndig_q;
    ack_d   = ack_q;
    adj     = add3_all(work_q);
    case (state_q)
      IDLE: begin
        if (req) begin
          shift_d = bin;
          work_d  = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {work_d, shift_d} = {adj, shift_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          bcd_d   = work_d;
          ndig_d  = count_digits(work_d);
          ack_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!req) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      bcd_q   <= '0;
      ndig_q  <= 8'd1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      bcd_q   <= bcd_d;
      ndig_q  <= ndig_d;
    end
  end

  // Working registers are don't-care outside SHIFT, so they carry no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    work_q  <= work_d;
  end

  assign ack  = ack_q;
  assign bcd  = bcd_q;
  assign ndig = ndig_q;

endmodule
